// File: rtl/us_tx_burst_serializer_pkg.sv
// Shared definitions for the ultrasound TX burst serializer: FSM encoding and default widths.
package us_tx_burst_serializer_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int PAT_W_DEF = 64;
  localparam int DIV_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } tx_state_e;

endpackage

// File: rtl/us_tx_bit_timer.sv
// Bit-period down-counter: counts div-1 down to 0 and pulses wrap on the last cycle of each bit.
module us_tx_bit_timer
  import us_tx_burst_serializer_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             wrap
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;

  assign wrap = en && (cnt_q == '0);

  // The period is captured on load so a changing div input cannot disturb a running burst.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      div_q <= div;
      cnt_q <= div - DIV_W'(1);
    end else if (en) begin
      if (cnt_q == '0) cnt_q <= div_q - DIV_W'(1);
      else             cnt_q <= cnt_q - DIV_W'(1);
    end
  end

endmodule

// File: rtl/us_tx_burst_serializer.sv
// Serializes a latched pulse pattern LSB-first onto the TX driver line, one bit per div clocks.
module us_tx_burst_serializer
  import us_tx_burst_serializer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PAT_W = PAT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] num_of_bits,
  input  logic [PAT_W-1:0] pattern,
  input  logic [DIV_W-1:0] bit_div,
  input  logic             start,
  input  logic             abort,
  output logic             tx_out,
  output logic             tx_oe,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_idx
);

  tx_state_e        state_q, state_d;
  logic [PAT_W-1:0] sr_q;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] bit_idx_q;
  logic [CNT_W-1:0] n_in;
  logic [DIV_W-1:0] div_eff;
  logic             load;
  logic             wrap;
  logic             last_bit;

  // Over-long requests are clamped to the pattern width rather than wrapping modulo 2^CNT_W.
  assign n_in     = (num_of_bits > CNT_W'(PAT_W)) ? CNT_W'(PAT_W) : num_of_bits;
  assign div_eff  = (bit_div == '0) ? DIV_W'(1) : bit_div;
  assign last_bit = (bit_idx_q == n_q - CNT_W'(1));

  us_tx_bit_timer #(.DIV_W(DIV_W)) u_bit_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .en      (state_q == ST_SHIFT),
    .div     (div_eff),
    .wrap    (wrap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            load    = 1'b1;
            state_d = (n_in == '0) ? ST_FINISH : ST_SHIFT;
          end
        end
        ST_SHIFT:  if (wrap && last_bit) state_d = ST_FINISH;
        ST_FINISH: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q      <= '0;
      n_q       <= '0;
      bit_idx_q <= '0;
    end else if (load) begin
      sr_q      <= pattern;
      n_q       <= n_in;
      bit_idx_q <= '0;
    end else if (abort) begin
      bit_idx_q <= '0;
    end else if (state_q == ST_SHIFT && wrap) begin
      if (last_bit) begin
        bit_idx_q <= '0;
      end else begin
        sr_q      <= sr_q >> 1;
        bit_idx_q <= bit_idx_q + CNT_W'(1);
      end
    end
  end

  // Outputs decode straight from registers so an async reset drops them immediately.
  assign tx_oe   = (state_q == ST_SHIFT);
  assign tx_out  = tx_oe & sr_q[0];
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_FINISH);
  assign bit_idx = bit_idx_q;

endmodule

// File: tb/tb_us_tx_burst_serializer.sv
// Directed self-checking bench for us_tx_burst_serializer.
module tb_us_tx_burst_serializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  num_of_bits;
  logic [63:0] pattern;
  logic [15:0] bit_div;
  logic        start;
  logic        abort;
  logic        tx_out;
  logic        tx_oe;
  logic        busy;
  logic        done;
  logic [7:0]  bit_idx;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  us_tx_burst_serializer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .num_of_bits (num_of_bits),
    .pattern     (pattern),
    .bit_div     (bit_div),
    .start       (start),
    .abort       (abort),
    .tx_out      (tx_out),
    .tx_oe       (tx_oe),
    .busy        (busy),
    .done        (done),
    .bit_idx     (bit_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Pulses start (or leaves it high when hold=1) and walks the whole burst, checking
  // every cycle. chg_at corrupts pattern/num_of_bits at that bit; pulse_at strobes start.
  task automatic run_burst(input string tag, input int n_exp, input logic [63:0] pat,
                           input int div, input int chg_at, input int pulse_at, input bit hold);
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    for (int k = 0; k < n_exp; k++) begin
      for (int d = 0; d < div; d++) begin
        if (k == chg_at && d == 0) begin
          pattern     = ~pattern;
          num_of_bits = 8'd5;
        end
        if (k == pulse_at && d == 0) start = 1'b1;
        chk($sformatf("%s_oe_b%0d_c%0d", tag, k, d), {63'd0, tx_oe}, 64'd1);
        chk($sformatf("%s_out_b%0d_c%0d", tag, k, d), {63'd0, tx_out}, {63'd0, pat[k]});
        chk($sformatf("%s_idx_b%0d_c%0d", tag, k, d), {56'd0, bit_idx}, 64'(k));
        chk($sformatf("%s_busy_b%0d_c%0d", tag, k, d), {63'd0, busy}, 64'd1);
        tick();
        if (k == pulse_at && d == 0) start = 1'b0;
      end
    end
    chk($sformatf("%s_done", tag), {63'd0, done}, 64'd1);
    chk($sformatf("%s_fin_oe", tag), {63'd0, tx_oe}, 64'd0);
    chk($sformatf("%s_fin_busy", tag), {63'd0, busy}, 64'd1);
    tick();
    chk($sformatf("%s_idle_busy", tag), {63'd0, busy}, 64'd0);
    chk($sformatf("%s_idle_done", tag), {63'd0, done}, 64'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    num_of_bits = 8'd20;
    pattern     = 64'h0;
    bit_div     = 16'd1;
    start       = 1'b0;
    abort       = 1'b0;
    #1;
    chk("rst_tx_out", {63'd0, tx_out}, 64'd0);
    chk("rst_tx_oe", {63'd0, tx_oe}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_bit_idx", {56'd0, bit_idx}, 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // 1: default 20-bit burst, one clock per bit
    num_of_bits = 8'd20; pattern = 64'hA5A5A; bit_div = 16'd1;
    run_burst("dflt", 20, 64'hA5A5A, 1, -1, -1, 1'b0);

    // 2: divider of 4, then divider 0 behaving as 1
    num_of_bits = 8'd3; pattern = 64'b101; bit_div = 16'd4;
    run_burst("div4", 3, 64'b101, 4, -1, -1, 1'b0);
    bit_div = 16'd0;
    run_burst("div0", 3, 64'b101, 1, -1, -1, 1'b0);

    // 3: zero length and clamp to 64 bits
    num_of_bits = 8'd0; pattern = 64'hFFFF; bit_div = 16'd1;
    run_burst("len0", 0, 64'hFFFF, 1, -1, -1, 1'b0);
    num_of_bits = 8'd200; pattern = 64'hDEADBEEF01234567; bit_div = 16'd1;
    run_burst("clamp", 64, 64'hDEADBEEF01234567, 1, -1, -1, 1'b0);

    // 4: abort on the 5th bit, then a fresh burst two cycles later
    num_of_bits = 8'd20; pattern = 64'hA5A5A; bit_div = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("abort_pre_idx", {56'd0, bit_idx}, 64'd4);
    chk("abort_pre_oe", {63'd0, tx_oe}, 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_oe", {63'd0, tx_oe}, 64'd0);
    chk("abort_out", {63'd0, tx_out}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    tick();
    chk("abort_done2", {63'd0, done}, 64'd0);
    run_burst("post_abort", 20, 64'hA5A5A, 1, -1, -1, 1'b0);

    // start and abort together: abort wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("st_ab_busy", {63'd0, busy}, 64'd0);

    // 5: mid-burst input changes at bit 3, start strobe at bit 6, held start
    num_of_bits = 8'd20; pattern = 64'h3C96F; bit_div = 16'd2;
    run_burst("midchg", 20, 64'h3C96F, 2, 3, 6, 1'b0);
    tick();
    chk("no_queue_busy", {63'd0, busy}, 64'd0);
    num_of_bits = 8'd2; pattern = 64'b10; bit_div = 16'd1;
    run_burst("b2b_a", 2, 64'b10, 1, -1, -1, 1'b1);
    run_burst("b2b_b", 2, 64'b10, 1, -1, -1, 1'b0);

    // 6: async reset mid-burst
    num_of_bits = 8'd20; pattern = 64'hFFFFF; bit_div = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("prereset_oe", {63'd0, tx_oe}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_tx_out", {63'd0, tx_out}, 64'd0);
    chk("arst_tx_oe", {63'd0, tx_oe}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_bit_idx", {56'd0, bit_idx}, 64'd0);
    #2;
    reset_n = 1'b1;
    tick();
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    num_of_bits = 8'd3; pattern = 64'b101; bit_div = 16'd1;
    run_burst("post_rst", 3, 64'b101, 1, -1, -1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
